// File: rtl/memory_round_controller.sv
// memory_round_controller
//   Runs one Memory Matrix round: captures the generator's board pattern on
//   start, reveals it for SHOW_CYCLES cycles, then scores player selections
//   until every pattern tile is found (WIN) or MAX_MISSES wrong picks (LOSE).
//   Holds the board generator between rounds' capture and result.
//
// Ports
//   clk, reset        system clock, asynchronous active-high reset
//   start             level; begins a round from IDLE, WIN or LOSE
//   board_values      pattern from the generator, one bit per tile
//   gen_enable        advances the generator LFSR (idle/result states only)
//   sel_valid         single-cycle strobe for a player selection
//   sel_index         index of the selected tile
//   display           tile lamps
//   showing/playing   state flags for SHOW / PLAY
//   win/lose          round result flags
//   hits, misses      round score counters
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for start, display dark, generator running
// SHOW  | pattern revealed, timer counting the reveal window
// PLAY  | accepting selections, display shows tiles found so far
// WIN   | all pattern tiles found; results held until start
// LOSE  | miss limit reached; answer revealed until start

module memory_round_controller #(
  parameter int TILES       = 16,
  parameter int SHOW_CYCLES = 100,
  parameter int MAX_MISSES  = 3
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [TILES-1:0]                board_values,
  output logic                            gen_enable,
  input  logic                            sel_valid,
  input  logic [$clog2(TILES)-1:0]        sel_index,
  output logic [TILES-1:0]                display,
  output logic                            showing,
  output logic                            playing,
  output logic                            win,
  output logic                            lose,
  output logic [$clog2(TILES+1)-1:0]      hits,
  output logic [$clog2(MAX_MISSES+1)-1:0] misses
);

  localparam int HW = $clog2(TILES + 1);
  localparam int MW = $clog2(MAX_MISSES + 1);
  localparam int TW = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SHOW = 3'd1,
    PLAY = 3'd2,
    WIN  = 3'd3,
    LOSE = 3'd4
  } state_t;

  state_t           state, state_n;
  logic [TILES-1:0] target, target_n;
  logic [TILES-1:0] found, found_n;
  logic [TW-1:0]    timer, timer_n;
  logic [HW-1:0]    hits_q, hits_n;
  logic [MW-1:0]    misses_q, misses_n;

  logic [TILES-1:0] sel_mask;
  logic             sel_in_range;
  logic [MW-1:0]    misses_inc;

  assign sel_mask     = {{(TILES-1){1'b0}}, 1'b1} << sel_index;
  assign sel_in_range = (32'(sel_index) < 32'(TILES));
  assign misses_inc   = misses_q + MW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      target   <= '0;
      found    <= '0;
      timer    <= '0;
      hits_q   <= '0;
      misses_q <= '0;
    end else begin
      state    <= state_n;
      target   <= target_n;
      found    <= found_n;
      timer    <= timer_n;
      hits_q   <= hits_n;
      misses_q <= misses_n;
    end
  end

  always_comb begin
    state_n  = state;
    target_n = target;
    found_n  = found;
    timer_n  = timer;
    hits_n   = hits_q;
    misses_n = misses_q;
    case (state)
      IDLE, WIN, LOSE: begin
        if (start) begin
          state_n  = SHOW;
          target_n = board_values;
          found_n  = '0;
          timer_n  = '0;
          hits_n   = '0;
          misses_n = '0;
        end
      end
      SHOW: begin
        if (timer == TW'(SHOW_CYCLES - 1)) begin
          state_n = PLAY;
          timer_n = '0;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      PLAY: begin
        if (sel_valid && sel_in_range) begin
          if ((target & sel_mask) != '0) begin
            // re-selecting an already found tile is neither a hit nor a miss
            if ((found & sel_mask) == '0) begin
              found_n = found | sel_mask;
              hits_n  = hits_q + HW'(1);
              if ((found | sel_mask) == target) state_n = WIN;
            end
          end else begin
            misses_n = misses_inc;
            if (misses_inc == MW'(MAX_MISSES)) state_n = LOSE;
          end
        end else if (found == target) begin
          // covers an empty board, which has nothing to find
          state_n = WIN;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign gen_enable = (state == IDLE) || (state == WIN) || (state == LOSE);
  assign showing    = (state == SHOW);
  assign playing    = (state == PLAY);
  assign win        = (state == WIN);
  assign lose       = (state == LOSE);
  assign hits       = hits_q;
  assign misses     = misses_q;
  assign display    = (state == IDLE) ? '0 :
                      (state == PLAY) ? found : target;

endmodule

// File: tb/tb_memory_round_controller.sv
module tb_memory_round_controller;

  localparam int TILES       = 16;
  localparam int SHOW_CYCLES = 4;
  localparam int MAX_MISSES  = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] board_values;
  logic        gen_enable;
  logic        sel_valid;
  logic [3:0]  sel_index;
  logic [15:0] display;
  logic        showing, playing, win, lose;
  logic [4:0]  hits;
  logic [1:0]  misses;

  int checks   = 0;
  int failures = 0;

  memory_round_controller #(
    .TILES(TILES), .SHOW_CYCLES(SHOW_CYCLES), .MAX_MISSES(MAX_MISSES)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .board_values(board_values),
    .gen_enable(gen_enable), .sel_valid(sel_valid), .sel_index(sel_index),
    .display(display), .showing(showing), .playing(playing), .win(win),
    .lose(lose), .hits(hits), .misses(misses)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // flags packed as {gen_enable, showing, playing, win, lose}
  task automatic chk_all(input string tag, input logic [4:0] flags, input logic [15:0] disp,
                         input logic [4:0] h, input logic [1:0] m);
    chk({tag, "_flags"}, {27'd0, gen_enable, showing, playing, win, lose}, {27'd0, flags});
    chk({tag, "_display"}, {16'd0, display}, {16'd0, disp});
    chk({tag, "_hits"}, {27'd0, hits}, {27'd0, h});
    chk({tag, "_misses"}, {30'd0, misses}, {30'd0, m});
  endtask

  task automatic start_round(input logic [15:0] board);
    board_values = board;
    start = 1'b1;
    step();
    start = 1'b0;
    board_values = 16'hFFFF;
  endtask

  task automatic select(input logic [3:0] idx);
    sel_valid = 1'b1;
    sel_index = idx;
    step();
    sel_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; board_values = '0; sel_valid = 1'b0; sel_index = '0;
    step(); step();
    chk_all("reset_hold", 5'b10000, 16'h0000, 5'd0, 2'd0);
    reset = 1'b0;
    step();
    chk_all("idle", 5'b10000, 16'h0000, 5'd0, 2'd0);

    // async reset mid-clock during SHOW
    start_round(16'h00FF);
    chk_all("pre_reset_show", 5'b01000, 16'h00FF, 5'd0, 2'd0);
    #2 reset = 1'b1;
    #1;
    chk_all("async_reset", 5'b10000, 16'h0000, 5'd0, 2'd0);
    step();
    reset = 1'b0;
    step();

    // reveal window and win
    start_round(16'h0013);
    chk_all("show1", 5'b01000, 16'h0013, 5'd0, 2'd0);
    for (int i = 2; i <= SHOW_CYCLES; i++) begin
      step();
      chk_all($sformatf("show%0d", i), 5'b01000, 16'h0013, 5'd0, 2'd0);
    end
    step();
    chk_all("play_start", 5'b00100, 16'h0000, 5'd0, 2'd0);
    select(4'd0);
    chk_all("hit_0", 5'b00100, 16'h0001, 5'd1, 2'd0);
    select(4'd1);
    chk_all("hit_1", 5'b00100, 16'h0003, 5'd2, 2'd0);
    select(4'd4);
    chk_all("hit_4_win", 5'b10010, 16'h0013, 5'd3, 2'd0);
    step();
    chk_all("win_hold", 5'b10010, 16'h0013, 5'd3, 2'd0);

    // duplicates and selection during SHOW
    start_round(16'h0003);
    chk_all("dup_show1", 5'b01000, 16'h0003, 5'd0, 2'd0);
    select(4'd0);
    chk_all("dup_show_sel", 5'b01000, 16'h0003, 5'd0, 2'd0);
    step(); step();
    chk_all("dup_show4", 5'b01000, 16'h0003, 5'd0, 2'd0);
    step();
    chk_all("dup_play", 5'b00100, 16'h0000, 5'd0, 2'd0);
    select(4'd0);
    chk_all("dup_hit0", 5'b00100, 16'h0001, 5'd1, 2'd0);
    select(4'd0);
    chk_all("dup_again0", 5'b00100, 16'h0001, 5'd1, 2'd0);
    select(4'd1);
    chk_all("dup_win", 5'b10010, 16'h0003, 5'd2, 2'd0);

    // lose
    start_round(16'h8000);
    step(); step(); step();
    chk_all("lose_show4", 5'b01000, 16'h8000, 5'd0, 2'd0);
    step();
    chk_all("lose_play", 5'b00100, 16'h0000, 5'd0, 2'd0);
    select(4'd2);
    chk_all("miss1", 5'b00100, 16'h0000, 5'd0, 2'd1);
    select(4'd3);
    chk_all("miss2", 5'b00100, 16'h0000, 5'd0, 2'd2);
    select(4'd5);
    chk_all("miss3_lose", 5'b10001, 16'h8000, 5'd0, 2'd3);
    step();
    chk_all("lose_hold", 5'b10001, 16'h8000, 5'd0, 2'd3);

    // reset mid-round, then empty board
    start_round(16'h0003);
    step(); step(); step(); step();
    chk_all("rr_play", 5'b00100, 16'h0000, 5'd0, 2'd0);
    select(4'd0);
    chk_all("rr_hit", 5'b00100, 16'h0001, 5'd1, 2'd0);
    #2 reset = 1'b1;
    #1;
    chk_all("rr_reset", 5'b10000, 16'h0000, 5'd0, 2'd0);
    step();
    reset = 1'b0;
    step();
    chk_all("rr_idle", 5'b10000, 16'h0000, 5'd0, 2'd0);
    start_round(16'h0000);
    chk_all("empty_show1", 5'b01000, 16'h0000, 5'd0, 2'd0);
    step(); step(); step();
    chk_all("empty_show4", 5'b01000, 16'h0000, 5'd0, 2'd0);
    step();
    chk_all("empty_play", 5'b00100, 16'h0000, 5'd0, 2'd0);
    step();
    chk_all("empty_win", 5'b10010, 16'h0000, 5'd0, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory_round_controller.md
# memory_round_controller

Consumes the random board pattern from the board generator and runs one Memory Matrix round. It captures the pattern, lights it for a fixed reveal window, then takes player tile selections, tracks hits and misses, and declares win or lose. It sits between the board generator (upstream) and the display/score logic (downstream). It also drives the generator's enable so the LFSR free-runs between rounds and holds during a round.

## Interface
- `TILES`, default 16: board size in tiles; one bit per tile.
- `SHOW_CYCLES`, default 100: length of the reveal window in clk cycles; must be ≥1.
- `MAX_MISSES`, default 3: number of wrong selections that ends the round in LOSE; must be ≥1.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; forces IDLE and clears all registers.
- `start`  in  1  level; sampled each cycle; begins a round from IDLE, WIN or LOSE.
- `board_values`  in  TILES  pattern from the generator; bit i=1 means tile i is part of the pattern.
- `gen_enable`  out  1  advances the generator LFSR.
- `sel_valid`  in  1  single-cycle strobe: player selected a tile.
- `sel_index`  in  $clog2(TILES)  index of the selected tile.
- `display`  out  TILES  tile lamps.
- `showing`  out  1  high in SHOW.
- `playing`  out  1  high in PLAY.
- `win`  out  1  high in WIN.
- `lose`  out  1  high in LOSE.
- `hits`  out  $clog2(TILES+1)  correct distinct tiles found this round.
- `misses`  out  $clog2(MAX_MISSES+1)  wrong selections this round.

## Operation
- Internal registers: `state` (IDLE/SHOW/PLAY/WIN/LOSE), `target[TILES]`, `found[TILES]`, `timer` ($clog2(SHOW_CYCLES) bits, min 1), `hits`, `misses`.
- All outputs decode combinationally from the registered state and registers.
- `gen_enable` = 1 in IDLE, WIN and LOSE, and 0 in SHOW and PLAY.
- `display`:
  - 0 in IDLE.
  - `target` in SHOW, WIN and LOSE (LOSE reveals the answer).
  - `found` in PLAY.
- IDLE, WIN or LOSE, with `start`=1:
  - target ← board_values; found, hits, misses and timer ← 0.
  - Next state is SHOW.
  - Without `start`, the state holds.
- SHOW:
  - timer increments each cycle.
  - When timer==SHOW_CYCLES-1, the next state is PLAY and timer ← 0.
  - `sel_valid` and `start` are ignored.
- PLAY, when `sel_valid`=1 and sel_index<TILES:
  - target[i]=1 and found[i]=0: found[i] ← 1 and hits ← hits+1. If found|onehot(i) == target, the next state is WIN.
  - target[i]=1 and found[i]=1: duplicate; no change.
  - target[i]=0: misses ← misses+1. If misses+1 == MAX_MISSES, the next state is LOSE.
- PLAY, other cases:
  - sel_index ≥ TILES is ignored.
  - If found==target with no selection (including an all-zero board), the next state is WIN.
  - `start` is ignored.
- WIN and LOSE hold `hits`, `misses` and `display` until `start` or `reset`.
- Counters never wrap:
  - hits ≤ popcount(target).
  - misses ≤ MAX_MISSES, because LOSE is entered on reaching it.

## Timing
- Reset: asynchronous assertion, sampled release.
- While `reset` is asserted, and after it:
  - state = IDLE; target, found, timer, hits and misses = 0.
  - display=0; showing, playing, win and lose = 0.
  - gen_enable=1.
- Reset mid-round aborts immediately to IDLE; no partial results survive.
- `start` at edge t: board_values is captured at t, and SHOW is visible from t+1.
- SHOW lasts exactly SHOW_CYCLES cycles; PLAY is first visible at t+1+SHOW_CYCLES.
- A selection at edge t updates found, hits and misses at t+1. A completing hit or final miss shows win or lose at t+1 (same edge); there is no extra cycle.
- Selections are processed back-to-back, one per cycle, with no throttling.
- `start` held high in WIN or LOSE restarts on the first cycle and re-captures board_values.

## Test plan
Bench parameters: TILES=16, SHOW_CYCLES=4, MAX_MISSES=3.

- **Reset values:** assert reset mid-clock. Outputs go to zero and gen_enable=1 asynchronously, before the next edge.
- **Reveal window and win:** board_values=16'h0013, start pulse. showing=1 for exactly 4 cycles with display=0013, then playing=1 and display=0000. Select 0, 1, 4 on consecutive cycles → hits 1, 2, 3; win=1 the cycle after index 4 is selected; display=0013.
- **Duplicates and ignored input:** board 16'h0003. Select 0, 0, 1 → hits=2, misses=0, win. A sel_valid pulse during SHOW changes nothing.
- **Lose:** board 16'h8000. Select 2, 3, 5 → misses 1, 2, 3; lose=1 the cycle after the third miss; display=8000; gen_enable=1.
- **Reset mid-round and restart:** reset during PLAY after one hit → IDLE with all counters 0. Then start with board 16'h0000 → SHOW for 4 cycles, PLAY for one cycle, then win.
